clk_div_bank: RTL

Parametrised bank of NUM_CH independent integer clock dividers driven from one system clock.
- Each channel produces a 50%-duty divided clock-enable-style output and a one-cycle tick strobe.
- Divide ratios are reprogrammable at run time, glitch-free, through a valid/ready config port.
- Sits beside the system clock source and feeds low-rate peripheral timing (UART baud, LED/scan, sampling), replacing fixed-ratio dividers.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_bank_if.sv | 17 +
 rtl/clk_div_channel.sv | 69 ++++++
 rtl/clk_div_bank.sv | 54 +++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and divide constants for the clock-divider bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 24;

  // Standard half-period divide values (toggle every D+1 cycles)
  localparam int D_1KHZ = 99999;
  localparam int D_BAUD = 9;
  localparam int D_SCAN = 99;
  localparam int D_FAST = 7;

  // Channel index width, never narrower than one bit
  function automatic int ch_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W_DEF = ch_w_of(NUM_CH_DEF);

endpackage

// File: rtl/clk_div_bank_if.sv
// Config write port of the divider bank: channel index plus new divide value.
// Latency: transfer completes on the rising edge where cfg_valid && cfg_ready.
// Backpressure: cfg_ready drops while the addressed channel holds an unapplied value.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_channel.sv
// One integer divider: 50%-duty clk and a one-cycle tick every div_q+1 cycles.
// Latency: registered outputs; first toggle div_q+1 edges after restart.
// Backpressure: busy stays high from a write until the value is applied.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] init_div,
  output logic             busy,
  output logic             clk,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pend;
  logic             pend_valid;
  logic             restart;
  logic             term;

  // sync and disable both park the channel at phase zero
  assign restart = sync | ~en;
  // cnt never passes div_q, so even the all-ones divide cannot overflow
  assign term    = (cnt == div_q);
  assign busy    = pend_valid;

  // Counter, output toggle, and pending-divide hand-over at phase boundaries
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt        <= '0;
      clk        <= 1'b0;
      tick       <= 1'b0;
      div_q      <= init_div;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (restart) begin
        cnt  <= '0;
        clk  <= 1'b0;
        tick <= 1'b0;
      end else if (term) begin
        cnt  <= '0;
        clk  <= ~clk;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // A new ratio only takes over where a count restarts from zero, so no
      // half-period is ever cut short or stretched. wr is never asserted
      // while pend_valid is set, so apply and write cannot collide.
      if ((restart || term) && pend_valid) begin
        div_q      <= pend;
        pend_valid <= 1'b0;
      end else if (wr) begin
        pend       <= wr_div;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent, run-time reprogrammable integer clock dividers.
// Latency: outputs registered; a new divide applies at the channel's next terminal count.
// Backpressure: cfg_ready low while the addressed channel has a pending divide.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH   = NUM_CH_DEF,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(D_FAST), CNT_W'(D_SCAN),
                                                 CNT_W'(D_BAUD), CNT_W'(D_1KHZ)},
  parameter int                      CH_W     = ch_w_of(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] en_in,
  input  logic              sync_in,
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick_out
);

  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] wr;
  logic              ready;

  // Ready follows the addressed channel; out-of-range indices always accept
  // (and the write is dropped because no channel decodes it)
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) ready = ~busy[i];
    end
  end

  assign cfg.cfg_ready = ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(g));

    clk_div_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .en       (en_in[g]),
      .sync     (sync_in),
      .wr       (wr[g]),
      .wr_div   (cfg.cfg_div),
      .init_div (DIV_INIT[g*CNT_W +: CNT_W]),
      .busy     (busy[g]),
      .clk      (clk_out[g]),
      .tick     (tick_out[g])
    );
  end

endmodule
